// File: rtl/hmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// Interfaces for the higher-memory arbiter.
//
// reset_if        : carries the synchronous, active-high reset shared by the
//                   arbiter and the main memory.
//                     master : drives reset
//                     slave  : observes reset
//
// hmem_arbiter_if : groups both cache-side request ports and the single
//                   main-memory port.
//                     req0_*  : I-cache port (read only)
//                     req1_*  : D-cache port (read / write)
//                     mem_*   : main-memory port
//                   slave  : arbiter view (takes requests, drives memory)
//                   master : environment view (caches + memory)
// -----------------------------------------------------------------------------

interface reset_if;
    logic reset;

    modport master (output reset);
    modport slave  (input  reset);
endinterface

interface hmem_arbiter_if #(
    parameter int XLEN = 32
);
    // I-cache port
    logic            req0_valid;
    logic [XLEN-1:0] req0_address;
    logic            req0_fulfilled;
    logic [XLEN-1:0] req0_loaded_word;

    // D-cache port
    logic            req1_valid;
    logic            req1_op;
    logic [XLEN-1:0] req1_address;
    logic [XLEN-1:0] req1_store_word;
    logic            req1_fulfilled;
    logic [XLEN-1:0] req1_loaded_word;

    // Main-memory port
    logic            mem_valid;
    logic            mem_op;
    logic [XLEN-1:0] mem_address;
    logic [XLEN-1:0] mem_store_word;
    logic            mem_fulfilled;
    logic [XLEN-1:0] mem_loaded_word;

    modport slave (
        input  req0_valid, req0_address,
        input  req1_valid, req1_op, req1_address, req1_store_word,
        input  mem_fulfilled, mem_loaded_word,
        output req0_fulfilled, req0_loaded_word,
        output req1_fulfilled, req1_loaded_word,
        output mem_valid, mem_op, mem_address, mem_store_word
    );

    modport master (
        output req0_valid, req0_address,
        output req1_valid, req1_op, req1_address, req1_store_word,
        output mem_fulfilled, mem_loaded_word,
        input  req0_fulfilled, req0_loaded_word,
        input  req1_fulfilled, req1_loaded_word,
        input  mem_valid, mem_op, mem_address, mem_store_word
    );
endinterface

// File: rtl/hmem_arbiter.sv
// -----------------------------------------------------------------------------
// hmem_arbiter
//
// Round-robin arbiter between the I-cache (port 0, read only) and the D-cache
// (port 1, read/write) higher-memory ports and the single main-memory port.
// A grant is locked for a full line burst (BURST_LEN words) so that a line
// fill or writeback is never interleaved with the other port's traffic.
//
// Ports:
//   clk     : clock, all state updates on posedge
//   rst_if  : reset_if.slave, rst_if.reset is synchronous active-high
//   bus     : hmem_arbiter_if.slave
//               req0_valid/address          -> in,  req0_fulfilled/loaded_word -> out
//               req1_valid/op/address/store -> in,  req1_fulfilled/loaded_word -> out
//               mem_valid/op/address/store  -> out, mem_fulfilled/loaded_word  -> in
//
// The memory request and the fulfilled pulse are steered combinationally from
// the granted port, so the only registered state is the FSM state, the
// round-robin pointer and the beat counter.
// -----------------------------------------------------------------------------

module hmem_arbiter #(
    parameter int XLEN      = 32,
    parameter int LINE_SIZE = 32
) (
    input  logic          clk,
    reset_if.slave        rst_if,
    hmem_arbiter_if.slave bus
);

    localparam int BURST_LEN = LINE_SIZE / 4;
    localparam int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    if (XLEN != 32) begin : g_bad_xlen
        $error("hmem_arbiter: only XLEN=32 is supported");
    end

    if (((LINE_SIZE % 4) != 0) || ((LINE_SIZE & (LINE_SIZE - 1)) != 0)) begin : g_bad_line
        $error("hmem_arbiter: LINE_SIZE must be a power of 2 and a multiple of 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_e;

    state_e            state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic [BEAT_W-1:0] beat_q,       beat_d;

    logic              own_port_s;
    logic              own_valid_s;
    logic              other_valid_s;
    logic              burst_end_s;

    logic              mem_valid_s;
    logic              mem_op_s;
    logic [XLEN-1:0]   mem_address_s;
    logic [XLEN-1:0]   mem_store_word_s;
    logic              req0_fulfilled_s;
    logic              req1_fulfilled_s;

    function automatic state_e grant_state(input logic port);
        grant_state = port ? ST_GRANT1 : ST_GRANT0;
    endfunction

    // State register: FSM state, round-robin pointer and beat counter.
    always_ff @(posedge clk) begin
        if (rst_if.reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;          // port 0 wins the first tie
            beat_q       <= {BEAT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
        end
    end

    // Burst bookkeeping for whichever port currently owns the grant.
    always_comb begin
        own_port_s    = (state_q == ST_GRANT1);
        own_valid_s   = own_port_s ? bus.req1_valid : bus.req0_valid;
        other_valid_s = own_port_s ? bus.req0_valid : bus.req1_valid;
        // A dropped request means no word is outstanding (requests are held
        // until fulfilled), so the burst can be closed early.
        burst_end_s   = (bus.mem_fulfilled && (beat_q == BEAT_LAST)) || !own_valid_s;
    end

    // Next-state logic: round-robin decision in IDLE, burst lock in GRANTn.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    state_d      = grant_state(!last_grant_q);
                    last_grant_d = !last_grant_q;
                    beat_d       = {BEAT_W{1'b0}};
                end else if (bus.req0_valid) begin
                    state_d      = ST_GRANT0;
                    last_grant_d = 1'b0;
                    beat_d       = {BEAT_W{1'b0}};
                end else if (bus.req1_valid) begin
                    state_d      = ST_GRANT1;
                    last_grant_d = 1'b1;
                    beat_d       = {BEAT_W{1'b0}};
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (burst_end_s) begin
                    // Other port first for fairness, then same port, else idle.
                    if (other_valid_s) begin
                        state_d      = grant_state(!own_port_s);
                        last_grant_d = !own_port_s;
                    end else if (own_valid_s) begin
                        state_d      = grant_state(own_port_s);
                        last_grant_d = own_port_s;
                    end else begin
                        state_d      = ST_IDLE;
                    end
                    beat_d = {BEAT_W{1'b0}};
                end else if (bus.mem_fulfilled) begin
                    beat_d = beat_q + BEAT_W'(1);
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                last_grant_d = 1'b1;
                beat_d       = {BEAT_W{1'b0}};
            end
        endcase
    end

    // Output logic: steer the granted port onto memory and route completion.
    always_comb begin
        mem_valid_s      = 1'b0;
        mem_op_s         = 1'b0;
        mem_address_s    = {XLEN{1'b0}};
        mem_store_word_s = {XLEN{1'b0}};
        req0_fulfilled_s = 1'b0;
        req1_fulfilled_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_valid_s = 1'b0;
            end
            ST_GRANT0: begin
                mem_valid_s      = bus.req0_valid;
                mem_op_s         = 1'b0;            // I-cache only reads
                mem_address_s    = bus.req0_address;
                mem_store_word_s = {XLEN{1'b0}};
                req0_fulfilled_s = bus.mem_fulfilled;
            end
            ST_GRANT1: begin
                mem_valid_s      = bus.req1_valid;
                mem_op_s         = bus.req1_op;
                mem_address_s    = bus.req1_address;
                mem_store_word_s = bus.req1_store_word;
                req1_fulfilled_s = bus.mem_fulfilled;
            end
            default: begin
                mem_valid_s = 1'b0;
            end
        endcase
    end

    assign bus.mem_valid        = mem_valid_s;
    assign bus.mem_op           = mem_op_s;
    assign bus.mem_address      = mem_address_s;
    assign bus.mem_store_word   = mem_store_word_s;
    assign bus.req0_fulfilled   = req0_fulfilled_s;
    assign bus.req1_fulfilled   = req1_fulfilled_s;
    // Read data is shared; only the port seeing fulfilled consumes it.
    assign bus.req0_loaded_word = bus.mem_loaded_word;
    assign bus.req1_loaded_word = bus.mem_loaded_word;

    hmem_arbiter_chk #(.XLEN(XLEN)) u_chk (
        .clk            (clk),
        .reset          (rst_if.reset),
        .req0_valid     (bus.req0_valid),
        .req0_address   (bus.req0_address),
        .req0_fulfilled (req0_fulfilled_s),
        .req1_valid     (bus.req1_valid),
        .req1_address   (bus.req1_address),
        .req1_fulfilled (req1_fulfilled_s),
        .mem_valid      (mem_valid_s),
        .mem_op         (mem_op_s),
        .mem_fulfilled  (bus.mem_fulfilled),
        .grant0         (state_q == ST_GRANT0),
        .idle           (state_q == ST_IDLE)
    );

endmodule

// -----------------------------------------------------------------------------
// hmem_arbiter_chk
//
// Protocol properties around the arbiter: request hold rules on both cache
// ports, port 0 never writing, and no memory completion while idle.
// -----------------------------------------------------------------------------
module hmem_arbiter_chk #(
    parameter int XLEN = 32
) (
    input logic            clk,
    input logic            reset,
    input logic            req0_valid,
    input logic [XLEN-1:0] req0_address,
    input logic            req0_fulfilled,
    input logic            req1_valid,
    input logic [XLEN-1:0] req1_address,
    input logic            req1_fulfilled,
    input logic            mem_valid,
    input logic            mem_op,
    input logic            mem_fulfilled,
    input logic            grant0,
    input logic            idle
);

    a_req0_hold: assert property (@(posedge clk) disable iff (reset)
        (!reset && req0_valid && !req0_fulfilled) |=> (req0_valid && $stable(req0_address)))
        else $error("req0 dropped or changed before fulfilled");

    a_req1_hold: assert property (@(posedge clk) disable iff (reset)
        (!reset && req1_valid && !req1_fulfilled) |=> (req1_valid && $stable(req1_address)))
        else $error("req1 dropped or changed before fulfilled");

    a_port0_read_only: assert property (@(posedge clk) disable iff (reset)
        (grant0 && mem_valid) |-> !mem_op)
        else $error("port 0 produced a memory write");

    a_no_fulfill_idle: assert property (@(posedge clk) disable iff (reset)
        idle |-> !mem_fulfilled)
        else $error("mem_fulfilled while idle");

endmodule
